icache_main_fsm_nway: RTL and testbench
=======================================

Name: icache_main_fsm_nway

Overview:
- Parametrised main control FSM for the instruction cache, successor to the fixed 4-way controller.
- Supports N ways and multi-beat AXI refills with an internal beat counter, so no external fill_finish is needed.
- Adds uncached (bypass) fetches and single-cycle CACOP tag-invalidate operations.
- Sits between the IF-stage request interface, the tag/valid and data RAMs, the request/miss/fill buffers, and the AXI read adapter.

Parameters:
- NWAY, 4: number of ways; all way-vector ports are NWAY bits wide.
- WAYW, 2: width of the way index, equal to clog2(NWAY); must be at least 1.
- BEATS, 16: AXI beats per cache line; BEATS must be at least 2.
- CNTW, 4: beat-counter width, equal to clog2(BEATS).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- valid  in  1  IF fetch request valid
- uncached  in  1  request is uncached; sampled only in LOOKUP
- cacop_valid  in  1  invalidate-way request
- cacop_way  in  WAYW  way index to invalidate
- hit  in  NWAY  one-hot tag-compare result
- lru_way_sel  in  NWAY  one-hot replacement way
- r_rdy  in  1  AXI read address accepted
- ret_valid  in  1  AXI read data beat valid
- ret_last  in  1  AXI last beat
- way_visit  out  NWAY  way touched, for LRU update
- way_sel_en  out  1  LRU update enable
- rbuf_we  out  1  request buffer write
- pbuf_we  out  1  physical-address buffer write
- mbuf_we  out  1  miss buffer write
- fbuf_we  out  1  fill buffer beat write
- beat_idx  out  CNTW  index of the current refill beat
- rdata_sel  out  2  read-data source: 00 fill buffer, 01 way data, 10 AXI bypass
- mem_we  out  NWAY  data RAM write enable
- tagv_we  out  NWAY  tag/valid RAM write enable
- tagv_clr  out  1  when 1, tag/valid write stores valid=0
- r_req  out  1  AXI read request
- r_len  out  8  burst length minus 1
- r_data_ready  out  1  ready to accept AXI read data
- data_valid  out  1  fetch data valid to IF
- cache_ready  out  1  new request accepted this cycle
- cacop_done  out  1  CACOP completed
- proto_err  out  1  sticky AXI last-beat mismatch flag

Behaviour:
- State register and beat counter reset asynchronously on rstn low: state = IDLE, beat count = 0, proto_err = 0.
- While rstn is low, every output is 0, including cache_ready.
- All outputs are combinational decodes of the state and inputs. Default value of every output is 0.
- States: IDLE, LOOKUP, MISS, REFILL, UC_REQ, UC_WAIT, CACOP.
- IDLE:
  - Outputs: rbuf_we = 1; cache_ready = !cacop_valid.
  - cacop_valid -> CACOP. CACOP has priority over valid; valid is not accepted that cycle.
  - else valid -> LOOKUP; else stay in IDLE.
- LOOKUP:
  - Always: pbuf_we = 1.
  - If uncached: go to UC_REQ; hit is ignored.
  - Else if |hit: rdata_sel = 01, data_valid = 1, way_visit = hit, way_sel_en = 1.
    - Also: rbuf_we = 1 and cache_ready = 1, both only when !cacop_valid.
    - Next: IDLE if cacop_valid, else LOOKUP if valid, else IDLE.
  - Else (miss): mbuf_we = 1 -> MISS.
- MISS:
  - Outputs: r_req = 1, r_len = BEATS-1.
  - r_rdy -> REFILL and beat count cleared to 0; else stay in MISS.
- REFILL:
  - Outputs: r_data_ready = 1, beat_idx = count.
  - On ret_valid: fbuf_we = 1 and count increments.
  - The final beat is ret_valid with count == BEATS-1. In that cycle:
    - mem_we = tagv_we = way_visit = lru_way_sel.
    - way_sel_en = 1, data_valid = 1, rdata_sel = 00.
    - rbuf_we = cache_ready = !cacop_valid.
    - Next state follows the LOOKUP-hit rule.
  - ret_last must equal (count == BEATS-1) on every ret_valid beat. On a mismatch, proto_err is set and stays set until reset; the FSM still ends the refill on the count.
  - No timeout.
- UC_REQ:
  - Outputs: r_req = 1, r_len = 0.
  - r_rdy -> UC_WAIT.
- UC_WAIT:
  - Outputs: r_data_ready = 1.
  - On ret_valid: rdata_sel = 10, data_valid = 1, rbuf_we = cache_ready = !cacop_valid.
  - Next state follows the LOOKUP-hit rule.
  - No RAM writes and no LRU update.
- CACOP:
  - Lasts one cycle.
  - Outputs: tagv_we = one-hot of cacop_way, tagv_clr = 1, cacop_done = 1.
  - Next: IDLE.
  - If cacop_way >= NWAY, tagv_we = 0 but cacop_done is still 1.
- ret_valid outside REFILL and UC_WAIT is ignored.
- r_rdy while r_req is low is ignored.
- An asynchronous reset during MISS, REFILL or UC_* abandons the transaction; AXI cleanup is the adapter's responsibility.

Test Plan:
- Reset, then valid=1, hit=0010 -> LOOKUP; a cycle with data_valid=1, way_visit=0010, cache_ready=1; back-to-back hits stay in LOOKUP.
- Miss with lru_way_sel=1000, BEATS=16 -> r_req=1 with r_len=15 until r_rdy; 16 ret_valid beats with gaps give beat_idx 0..15. On the 16th beat: mem_we = tagv_we = 1000, data_valid=1.
- Uncached request -> UC_REQ with r_len=0; after r_rdy and one ret_valid -> data_valid=1, rdata_sel=10, mem_we=0, way_sel_en=0.
- cacop_valid=1 with cacop_way=2 while valid=1 in IDLE -> CACOP; tagv_we=0100, tagv_clr=1, cacop_done=1, cache_ready=0 that cycle; then IDLE.
- ret_last asserted on beat 7 of 16 -> proto_err=1 and sticky; refill still completes on beat 15.
- rstn dropped mid-REFILL (beat 5) -> all outputs 0 immediately; after release the FSM is in IDLE with beat count 0; NWAY=8 build repeats the miss test with lru_way_sel=10000000.

Source files
------------

// File: rtl/icache_main_fsm_nway.sv
// Main control FSM for the N-way instruction cache: lookup, multi-beat refill,
// uncached bypass fetch and single-cycle CACOP tag invalidate.
module icache_main_fsm_nway #(
   parameter int NWAY  = 4,
   parameter int WAYW  = 2,
   parameter int BEATS = 16,
   parameter int CNTW  = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            valid,
   input  logic            uncached,
   input  logic            cacop_valid,
   input  logic [WAYW-1:0] cacop_way,
   input  logic [NWAY-1:0] hit,
   input  logic [NWAY-1:0] lru_way_sel,
   input  logic            r_rdy,
   input  logic            ret_valid,
   input  logic            ret_last,
   output logic [NWAY-1:0] way_visit,
   output logic            way_sel_en,
   output logic            rbuf_we,
   output logic            pbuf_we,
   output logic            mbuf_we,
   output logic            fbuf_we,
   output logic [CNTW-1:0] beat_idx,
   output logic [1:0]      rdata_sel,
   output logic [NWAY-1:0] mem_we,
   output logic [NWAY-1:0] tagv_we,
   output logic            tagv_clr,
   output logic            r_req,
   output logic [7:0]      r_len,
   output logic            r_data_ready,
   output logic            data_valid,
   output logic            cache_ready,
   output logic            cacop_done,
   output logic            proto_err
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOOKUP  = 3'd1,
      S_MISS    = 3'd2,
      S_REFILL  = 3'd3,
      S_UC_REQ  = 3'd4,
      S_UC_WAIT = 3'd5,
      S_CACOP   = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            perr_q, perr_d;
   logic            last_beat;

   assign last_beat = (cnt_q == CNTW'(BEATS - 1));
   assign proto_err = perr_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         perr_q  <= perr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      perr_d       = perr_q;
      way_visit    = '0;
      way_sel_en   = 1'b0;
      rbuf_we      = 1'b0;
      pbuf_we      = 1'b0;
      mbuf_we      = 1'b0;
      fbuf_we      = 1'b0;
      beat_idx     = '0;
      rdata_sel    = 2'b00;
      mem_we       = '0;
      tagv_we      = '0;
      tagv_clr     = 1'b0;
      r_req        = 1'b0;
      r_len        = 8'd0;
      r_data_ready = 1'b0;
      data_valid   = 1'b0;
      cache_ready  = 1'b0;
      cacop_done   = 1'b0;

      // Outputs are pure decodes, so they are forced low for the whole reset window.
      if (rstn) begin
         case (state_q)
            S_IDLE: begin
               rbuf_we     = 1'b1;
               cache_ready = !cacop_valid;
               if (cacop_valid)
                  state_d = S_CACOP;
               else if (valid)
                  state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
               pbuf_we = 1'b1;
               if (uncached) begin
                  state_d = S_UC_REQ;
               end else if (|hit) begin
                  rdata_sel   = 2'b01;
                  data_valid  = 1'b1;
                  way_visit   = hit;
                  way_sel_en  = 1'b1;
                  rbuf_we     = !cacop_valid;
                  cache_ready = !cacop_valid;
                  state_d     = (!cacop_valid && valid) ? S_LOOKUP : S_IDLE;
               end else begin
                  mbuf_we = 1'b1;
                  state_d = S_MISS;
               end
            end
            S_MISS: begin
               r_req = 1'b1;
               r_len = 8'(BEATS - 1);
               if (r_rdy) begin
                  cnt_d   = '0;
                  state_d = S_REFILL;
               end
            end
            S_REFILL: begin
               r_data_ready = 1'b1;
               beat_idx     = cnt_q;
               if (ret_valid) begin
                  fbuf_we = 1'b1;
                  if (ret_last != last_beat)
                     perr_d = 1'b1;
                  // The refill ends on the beat count alone; ret_last only feeds the error flag.
                  if (last_beat) begin
                     cnt_d       = '0;
                     mem_we      = lru_way_sel;
                     tagv_we     = lru_way_sel;
                     way_visit   = lru_way_sel;
                     way_sel_en  = 1'b1;
                     data_valid  = 1'b1;
                     rbuf_we     = !cacop_valid;
                     cache_ready = !cacop_valid;
                     state_d     = (!cacop_valid && valid) ? S_LOOKUP : S_IDLE;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            S_UC_REQ: begin
               r_req = 1'b1;
               if (r_rdy)
                  state_d = S_UC_WAIT;
            end
            S_UC_WAIT: begin
               r_data_ready = 1'b1;
               if (ret_valid) begin
                  rdata_sel   = 2'b10;
                  data_valid  = 1'b1;
                  rbuf_we     = !cacop_valid;
                  cache_ready = !cacop_valid;
                  state_d     = (!cacop_valid && valid) ? S_LOOKUP : S_IDLE;
               end
            end
            S_CACOP: begin
               // An out-of-range way index matches no bit and writes nothing.
               for (int i = 0; i < NWAY; i++)
                  tagv_we[i] = (cacop_way == WAYW'(i));
               tagv_clr   = 1'b1;
               cacop_done = 1'b1;
               state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_main_fsm_nway.sv
// Bench for icache_main_fsm_nway: vector table driven through a scoreboard on a
// 4-way instance, plus a miss/refill sequence on an 8-way instance.
module tb_icache_main_fsm_nway;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn, valid, uncached, cacop_valid, r_rdy, ret_valid, ret_last;
   logic [1:0] cacop_way;
   logic [3:0] hit, lru;
   logic [2:0] cacop_way8;
   logic [7:0] hit8, lru8;

   logic [3:0] way_visit, mem_we, tagv_we, beat_idx;
   logic [1:0] rdata_sel;
   logic [7:0] r_len;
   logic way_sel_en, rbuf_we, pbuf_we, mbuf_we, fbuf_we, tagv_clr, r_req;
   logic r_data_ready, data_valid, cache_ready, cacop_done, proto_err;

   logic [7:0] way_visit8, mem_we8, tagv_we8, r_len8;
   logic [3:0] beat_idx8;
   logic [1:0] rdata_sel8;
   logic way_sel_en8, rbuf_we8, pbuf_we8, mbuf_we8, fbuf_we8, tagv_clr8, r_req8;
   logic r_data_ready8, data_valid8, cache_ready8, cacop_done8, proto_err8;

   icache_main_fsm_nway #(.NWAY(4), .WAYW(2), .BEATS(16), .CNTW(4)) dut (
      .clk(clk), .rstn(rstn), .valid(valid), .uncached(uncached),
      .cacop_valid(cacop_valid), .cacop_way(cacop_way), .hit(hit), .lru_way_sel(lru),
      .r_rdy(r_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
      .way_visit(way_visit), .way_sel_en(way_sel_en), .rbuf_we(rbuf_we), .pbuf_we(pbuf_we),
      .mbuf_we(mbuf_we), .fbuf_we(fbuf_we), .beat_idx(beat_idx), .rdata_sel(rdata_sel),
      .mem_we(mem_we), .tagv_we(tagv_we), .tagv_clr(tagv_clr), .r_req(r_req), .r_len(r_len),
      .r_data_ready(r_data_ready), .data_valid(data_valid), .cache_ready(cache_ready),
      .cacop_done(cacop_done), .proto_err(proto_err)
   );

   icache_main_fsm_nway #(.NWAY(8), .WAYW(3), .BEATS(16), .CNTW(4)) dut8 (
      .clk(clk), .rstn(rstn), .valid(valid), .uncached(uncached),
      .cacop_valid(cacop_valid), .cacop_way(cacop_way8), .hit(hit8), .lru_way_sel(lru8),
      .r_rdy(r_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
      .way_visit(way_visit8), .way_sel_en(way_sel_en8), .rbuf_we(rbuf_we8), .pbuf_we(pbuf_we8),
      .mbuf_we(mbuf_we8), .fbuf_we(fbuf_we8), .beat_idx(beat_idx8), .rdata_sel(rdata_sel8),
      .mem_we(mem_we8), .tagv_we(tagv_we8), .tagv_clr(tagv_clr8), .r_req(r_req8), .r_len(r_len8),
      .r_data_ready(r_data_ready8), .data_valid(data_valid8), .cache_ready(cache_ready8),
      .cacop_done(cacop_done8), .proto_err(proto_err8)
   );

   typedef struct packed {
      logic       rstn, valid, uncached, cacop_valid;
      logic [1:0] cacop_way;
      logic [3:0] hit, lru;
      logic       r_rdy, ret_valid, ret_last;
   } in_t;

   typedef struct packed {
      logic       rbuf_we, pbuf_we, mbuf_we, fbuf_we;
      logic [3:0] beat_idx;
      logic [1:0] rdata_sel;
      logic [3:0] way_visit;
      logic       way_sel_en;
      logic [3:0] mem_we, tagv_we;
      logic       tagv_clr, r_req;
      logic [7:0] r_len;
      logic       r_data_ready, data_valid, cache_ready, cacop_done, proto_err;
   } out_t;

   typedef struct {
      in_t   i;
      out_t  o;
      string name;
   } vec_t;

   vec_t vecs[$];
   out_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic exp_pe = 1'b0;

   function automatic in_t mi(logic rs, logic v, logic u, logic cv, logic [1:0] cw,
                              logic [3:0] h, logic [3:0] l, logic rr, logic rv, logic rl);
      in_t x;
      x.rstn = rs; x.valid = v; x.uncached = u; x.cacop_valid = cv; x.cacop_way = cw;
      x.hit = h; x.lru = l; x.r_rdy = rr; x.ret_valid = rv; x.ret_last = rl;
      return x;
   endfunction

   function automatic out_t o_base();
      out_t o = '0;
      o.proto_err = exp_pe;
      return o;
   endfunction

   function automatic out_t o_idle(logic cv);
      out_t o = o_base();
      o.rbuf_we = 1'b1; o.cache_ready = !cv;
      return o;
   endfunction

   function automatic out_t o_hit(logic [3:0] h, logic cv);
      out_t o = o_base();
      o.pbuf_we = 1'b1; o.rdata_sel = 2'b01; o.data_valid = 1'b1; o.way_visit = h;
      o.way_sel_en = 1'b1; o.rbuf_we = !cv; o.cache_ready = !cv;
      return o;
   endfunction

   function automatic out_t o_ref(int b, logic rv, logic [3:0] l);
      out_t o = o_base();
      o.r_data_ready = 1'b1; o.beat_idx = 4'(b); o.fbuf_we = rv;
      if (rv && b == 15) begin
         o.mem_we = l; o.tagv_we = l; o.way_visit = l; o.way_sel_en = 1'b1;
         o.data_valid = 1'b1; o.rbuf_we = 1'b1; o.cache_ready = 1'b1;
      end
      return o;
   endfunction

   function automatic out_t o_cacop(logic [1:0] w);
      out_t o = o_base();
      logic [3:0] one = 4'b0001;
      o.tagv_we = one << w; o.tagv_clr = 1'b1; o.cacop_done = 1'b1;
      return o;
   endfunction

   task automatic add(input in_t i, input out_t o, input string n);
      vec_t v;
      v.i = i; v.o = o; v.name = n;
      vecs.push_back(v);
   endtask

   task automatic add_miss_refill(input logic [3:0] l, input bit gaps, input int err_at, input int nbeats);
      out_t o;
      logic rl;
      add(mi(1, 1, 0, 0, 0, 4'b0000, l, 0, 0, 0), o_idle(0), "idle_req");
      o = o_base(); o.pbuf_we = 1'b1; o.mbuf_we = 1'b1;
      add(mi(1, 0, 0, 0, 0, 4'b0000, l, 0, 0, 0), o, "lookup_miss");
      o = o_base(); o.r_req = 1'b1; o.r_len = 8'd15;
      add(mi(1, 0, 0, 0, 0, 4'b0000, l, 0, 0, 0), o, "miss_wait");
      add(mi(1, 0, 0, 0, 0, 4'b0000, l, 1, 0, 0), o, "miss_rdy");
      for (int b = 0; b < nbeats; b++) begin
         if (gaps)
            add(mi(1, 0, 0, 0, 0, 4'b0000, l, 0, 0, 0), o_ref(b, 0, l), $sformatf("refill_gap%0d", b));
         rl = (err_at >= 0) ? (b == err_at) : (b == 15);
         add(mi(1, 0, 0, 0, 0, 4'b0000, l, 0, 1, rl), o_ref(b, 1, l), $sformatf("refill_beat%0d", b));
         if (rl != (b == 15))
            exp_pe = 1'b1;
      end
   endtask

   function automatic out_t collect();
      out_t o;
      o.rbuf_we = rbuf_we; o.pbuf_we = pbuf_we; o.mbuf_we = mbuf_we; o.fbuf_we = fbuf_we;
      o.beat_idx = beat_idx; o.rdata_sel = rdata_sel; o.way_visit = way_visit;
      o.way_sel_en = way_sel_en; o.mem_we = mem_we; o.tagv_we = tagv_we; o.tagv_clr = tagv_clr;
      o.r_req = r_req; o.r_len = r_len; o.r_data_ready = r_data_ready; o.data_valid = data_valid;
      o.cache_ready = cache_ready; o.cacop_done = cacop_done; o.proto_err = proto_err;
      return o;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", n, act, exp);
      end else begin
         $display("ok   %s: %h", n, act);
      end
   endtask

   initial begin
      out_t o, act, exp;
      in_t  v;

      rstn = 1'b0; valid = 1'b0; uncached = 1'b0; cacop_valid = 1'b0; cacop_way = '0;
      hit = '0; lru = '0; r_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
      cacop_way8 = '0; hit8 = '0; lru8 = '0;

      // ---- vector table ----
      add(mi(0, 1, 0, 1, 0, 4'b0010, 4'b0000, 1, 1, 1), '0, "reset_hold");
      add(mi(0, 1, 0, 0, 0, 4'b0010, 4'b0000, 1, 1, 1), '0, "reset_hold2");
      // hits, back to back
      add(mi(1, 1, 0, 0, 0, 4'b0010, 4'b0000, 0, 0, 0), o_idle(0), "idle_accept");
      add(mi(1, 1, 0, 0, 0, 4'b0010, 4'b0000, 0, 0, 0), o_hit(4'b0010, 0), "hit_0010");
      add(mi(1, 1, 0, 0, 0, 4'b0100, 4'b0000, 0, 0, 0), o_hit(4'b0100, 0), "hit_0100_b2b");
      add(mi(1, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0), o_hit(4'b0001, 0), "hit_0001_last");
      add(mi(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 1, 1), o_idle(0), "idle_ignore_ret");
      // miss with gapped 16-beat refill into way 3
      add_miss_refill(4'b1000, 1, -1, 16);
      // uncached fetch
      add(mi(1, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0), o_idle(0), "uc_idle");
      o = o_base(); o.pbuf_we = 1'b1;
      add(mi(1, 0, 1, 0, 0, 4'b0010, 4'b0000, 0, 0, 0), o, "uc_lookup");
      o = o_base(); o.r_req = 1'b1;
      add(mi(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0), o, "uc_req_wait");
      add(mi(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0), o, "uc_req_rdy");
      o = o_base(); o.r_data_ready = 1'b1;
      add(mi(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0), o, "uc_wait");
      o.rdata_sel = 2'b10; o.data_valid = 1'b1; o.rbuf_we = 1'b1; o.cache_ready = 1'b1;
      add(mi(1, 0, 0, 0, 0, 4'b0000, 4'b1000, 0, 1, 1), o, "uc_data");
      // CACOP has priority over a concurrent fetch
      add(mi(1, 1, 0, 1, 2, 4'b0000, 4'b0000, 0, 0, 0), o_idle(1), "cacop_idle");
      add(mi(1, 1, 0, 0, 2, 4'b0000, 4'b0000, 0, 0, 0), o_cacop(2), "cacop_way2");
      add(mi(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0), o_idle(0), "cacop_back_idle");
      // hit while CACOP is pending: no accept, fall back to IDLE
      add(mi(1, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0), o_idle(0), "hitcop_idle");
      add(mi(1, 1, 0, 1, 0, 4'b0001, 4'b0000, 0, 0, 0), o_hit(4'b0001, 1), "hitcop_lookup");
      add(mi(1, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0), o_idle(1), "hitcop_idle2");
      add(mi(1, 0, 0, 0, 3, 4'b0000, 4'b0000, 0, 0, 0), o_cacop(3), "cacop_way3");
      // early ret_last on beat 7: sticky error, refill still ends on beat 15
      add_miss_refill(4'b0001, 0, 7, 16);
      add(mi(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0), o_idle(0), "perr_sticky_idle");
      // reset in the middle of a refill
      add_miss_refill(4'b0010, 1, -1, 5);
      add(mi(1, 0, 0, 0, 0, 4'b0000, 4'b0010, 0, 0, 0), o_ref(5, 0, 4'b0010), "refill_gap5_prerst");
      add(mi(0, 1, 0, 0, 0, 4'b0000, 4'b0010, 1, 1, 0), '0, "reset_mid_refill");
      exp_pe = 1'b0;
      add(mi(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0), o_idle(0), "after_reset_idle");
      add_miss_refill(4'b0100, 0, -1, 1);

      // ---- apply through the scoreboard ----
      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         v = vecs[k].i;
         rstn = v.rstn; valid = v.valid; uncached = v.uncached; cacop_valid = v.cacop_valid;
         cacop_way = v.cacop_way; hit = v.hit; lru = v.lru; r_rdy = v.r_rdy;
         ret_valid = v.ret_valid; ret_last = v.ret_last;
         sb.push_back(vecs[k].o);
         #2;
         act = collect();
         exp = sb.pop_front();
         total++;
         if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", vecs[k].name, act, exp);
         end else begin
            $display("ok   %s: %h", vecs[k].name, act);
         end
      end

      // ---- 8-way build: miss into way 7 ----
      @(negedge clk);
      rstn = 1'b0; valid = 1'b0; uncached = 1'b0; cacop_valid = 1'b0;
      r_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; hit8 = '0; lru8 = 8'h80;
      #2 chk("n8_reset", {23'd0, data_valid8, cache_ready8, mem_we8}, 32'd0);
      @(negedge clk); rstn = 1'b1; valid = 1'b1;
      #2 chk("n8_idle_ready", {31'd0, cache_ready8}, 32'd1);
      @(negedge clk); valid = 1'b0;
      #2 chk("n8_lookup_miss", {31'd0, mbuf_we8}, 32'd1);
      @(negedge clk);
      #2 chk("n8_miss_req", {23'd0, r_req8, r_len8}, {23'd0, 1'b1, 8'd15});
      @(negedge clk); r_rdy = 1'b1;
      #2 chk("n8_miss_rdy", {23'd0, r_req8, r_len8}, {23'd0, 1'b1, 8'd15});
      for (int b = 0; b < 16; b++) begin
         @(negedge clk); r_rdy = 1'b0; ret_valid = 1'b1; ret_last = (b == 15);
         #2 chk($sformatf("n8_beat%0d", b), {28'd0, beat_idx8}, 32'(b));
         if (b == 15) begin
            chk("n8_mem_we", {24'd0, mem_we8}, 32'h80);
            chk("n8_tagv_we", {24'd0, tagv_we8}, 32'h80);
            chk("n8_way_visit", {24'd0, way_visit8}, 32'h80);
            chk("n8_data_valid", {31'd0, data_valid8}, 32'd1);
         end
      end
      @(negedge clk); ret_valid = 1'b0; ret_last = 1'b0;
      #2 chk("n8_done_idle", {30'd0, cache_ready8, proto_err8}, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
